// File: rtl/final_adder_pipe_if.sv
// Operand/result handshake bundle for final_adder_pipe: valid/ready on the
// redundant sum/carry input side and on the binary product output side.
interface final_adder_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_product;

  // master: the Wallace array upstream plus the multiplier back end downstream
  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_product
  );

  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_product
  );
endinterface

// File: rtl/final_adder_pipe.sv
// Two-stage carry-propagate adder resolving Wallace-tree sum/carry vectors
// into the final product; low half added in stage 1, high half in stage 2.
module final_adder_pipe #(
  parameter int WIDTH = 64
) (
  input logic               clk,
  input logic               rst_n,
  final_adder_pipe_if.slave bus
);
  localparam int HALF = WIDTH / 2;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_cy_q, s1_cy_d;
  logic [HALF-1:0]  s1_lo_q, s1_lo_d;
  logic [HALF-1:0]  s1_sum_hi_q, s1_sum_hi_d;
  logic [HALF-1:0]  s1_cv_hi_q, s1_cv_hi_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_product_q, out_product_d;

  logic             s1_en;
  logic             s2_en;
  logic [WIDTH-1:0] cv;
  logic [HALF:0]    lo_add;
  logic [HALF-1:0]  hi_add;
  logic             unused_carry_msb;

  // The carry MSB would land at column WIDTH, outside the product.
  assign unused_carry_msb = bus.in_carry[WIDTH-1];

  always_comb begin
    s2_en  = ~out_valid_q | bus.out_ready;
    s1_en  = ~s1_valid_q | s2_en;
    cv     = {bus.in_carry[WIDTH-2:0], 1'b0};
    lo_add = {1'b0, bus.in_sum[HALF-1:0]} + {1'b0, cv[HALF-1:0]};
    hi_add = s1_sum_hi_q + s1_cv_hi_q + HALF'(s1_cy_q);
  end

  assign bus.in_ready    = rst_n & s1_en;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_product = out_product_q;

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_cy_d       = s1_cy_q;
    s1_lo_d       = s1_lo_q;
    s1_sum_hi_d   = s1_sum_hi_q;
    s1_cv_hi_d    = s1_cv_hi_q;
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;

    if (s1_en) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        {s1_cy_d, s1_lo_d} = lo_add;
        s1_sum_hi_d        = bus.in_sum[WIDTH-1:HALF];
        s1_cv_hi_d         = cv[WIDTH-1:HALF];
      end
    end

    // Stage 2 data only moves when stage 1 really holds a pair, so a bubble
    // never overwrites a result that is still being presented.
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_product_d = {hi_add, s1_lo_q};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_cy_q       <= 1'b0;
      s1_lo_q       <= '0;
      s1_sum_hi_q   <= '0;
      s1_cv_hi_q    <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_cy_q       <= s1_cy_d;
      s1_lo_q       <= s1_lo_d;
      s1_sum_hi_q   <= s1_sum_hi_d;
      s1_cv_hi_q    <= s1_cv_hi_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
    end
  end
endmodule
